// File: rtl/scr_writer_if.sv
// rtl/scr_writer_if.sv - character/clear request and screen-RAM write bus for scr_writer
//
// Purpose: bundles the character handshake, clear request, cursor/busy status
// and screen-RAM write port of the screen writer.
// Signals:
//   in_valid, in_char, in_ready  character offer handshake
//   clr, busy                    clear-screen request / clear in progress
//   cur_row, cur_col             cursor position
//   mem_addr, mem_data, mem_wen  registered screen-RAM write port
//   mem_ren                      screen-RAM read strobe (unused, held low)
// Modports: slave = the screen writer, master = the character source / RAM side.

interface scr_writer_if #(
   parameter int WORDSIZE     = 8,
   parameter int COL_ADDRSIZE = 7,
   parameter int ROW_ADDRSIZE = 5,
   parameter int ADDRSIZE     = 12
);
   logic                    in_valid;
   logic [WORDSIZE-1:0]     in_char;
   logic                    in_ready;
   logic                    clr;
   logic                    busy;
   logic [ROW_ADDRSIZE-1:0] cur_row;
   logic [COL_ADDRSIZE-1:0] cur_col;
   logic [ADDRSIZE-1:0]     mem_addr;
   logic [WORDSIZE-1:0]     mem_data;
   logic                    mem_wen;
   logic                    mem_ren;

   modport slave (
      input  in_valid, in_char, clr,
      output in_ready, busy, cur_row, cur_col, mem_addr, mem_data, mem_wen, mem_ren
   );

   modport master (
      output in_valid, in_char, clr,
      input  in_ready, busy, cur_row, cur_col, mem_addr, mem_data, mem_wen, mem_ren
   );
endinterface

// File: rtl/scr_writer.sv
// rtl/scr_writer.sv - text-screen writer: places characters in screen RAM, handles newline/backspace and clears
//
// Purpose: accepts ASCII characters, writes printable ones at the cursor and
// moves the cursor; newline/CR and column wrap blank the new line; clr (and
// reset) blank the whole screen. The screen wraps to row 0 instead of scrolling.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (starts a full-screen clear)
//   bus  scr_writer_if.slave: character handshake, clr/busy, cursor, RAM write port

module scr_writer #(
   parameter int COLS         = 70,
   parameter int ROWS         = 30,
   parameter int WORDSIZE     = 8,
   parameter int COL_ADDRSIZE = 7,
   parameter int ROW_ADDRSIZE = 5,
   parameter int ADDRSIZE     = 12
) (
   input  logic         clk,
   input  logic         rst,
   scr_writer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CLRLINE = 2'd1,
      S_CLRALL  = 2'd2
   } state_t;

   localparam logic [COL_ADDRSIZE-1:0] LAST_COL = COL_ADDRSIZE'(COLS - 1);
   localparam logic [ROW_ADDRSIZE-1:0] LAST_ROW = ROW_ADDRSIZE'(ROWS - 1);
   localparam logic [COL_ADDRSIZE-1:0] COL_ONE  = COL_ADDRSIZE'(1);
   localparam logic [ROW_ADDRSIZE-1:0] ROW_ONE  = ROW_ADDRSIZE'(1);
   localparam logic [WORDSIZE-1:0]     CH_SPACE = WORDSIZE'(8'h20);
   localparam logic [WORDSIZE-1:0]     CH_TILDE = WORDSIZE'(8'h7E);
   localparam logic [WORDSIZE-1:0]     CH_BS    = WORDSIZE'(8'h08);
   localparam logic [WORDSIZE-1:0]     CH_LF    = WORDSIZE'(8'h0A);
   localparam logic [WORDSIZE-1:0]     CH_CR    = WORDSIZE'(8'h0D);

   state_t                  state_q, state_nxt;
   logic [ROW_ADDRSIZE-1:0] cur_row_q, cur_row_nxt;
   logic [COL_ADDRSIZE-1:0] cur_col_q, cur_col_nxt;
   // clr_row is only meaningful in CLRALL; CLRLINE clears the cursor row.
   logic [ROW_ADDRSIZE-1:0] clr_row_q, clr_row_nxt;
   logic [COL_ADDRSIZE-1:0] clr_col_q, clr_col_nxt;
   logic [ADDRSIZE-1:0]     mem_addr_q, mem_addr_nxt;
   logic [WORDSIZE-1:0]     mem_data_q, mem_data_nxt;
   logic                    mem_wen_q, mem_wen_nxt;
   logic [ROW_ADDRSIZE-1:0] row_inc;

   assign bus.in_ready = (state_q == S_IDLE) && !bus.clr;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.cur_row  = cur_row_q;
   assign bus.cur_col  = cur_col_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_data = mem_data_q;
   assign bus.mem_wen  = mem_wen_q;
   assign bus.mem_ren  = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_CLRALL;
         cur_row_q  <= '0;
         cur_col_q  <= '0;
         clr_row_q  <= '0;
         clr_col_q  <= '0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_wen_q  <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         cur_row_q  <= cur_row_nxt;
         cur_col_q  <= cur_col_nxt;
         clr_row_q  <= clr_row_nxt;
         clr_col_q  <= clr_col_nxt;
         mem_addr_q <= mem_addr_nxt;
         mem_data_q <= mem_data_nxt;
         mem_wen_q  <= mem_wen_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      cur_row_nxt  = cur_row_q;
      cur_col_nxt  = cur_col_q;
      clr_row_nxt  = clr_row_q;
      clr_col_nxt  = clr_col_q;
      mem_addr_nxt = mem_addr_q;
      mem_data_nxt = mem_data_q;
      mem_wen_nxt  = 1'b0;
      // No scrolling: advancing past the last row lands on row 0.
      row_inc      = (cur_row_q == LAST_ROW) ? '0 : cur_row_q + ROW_ONE;

      case (state_q)
         S_IDLE: begin
            if (bus.clr) begin
               state_nxt   = S_CLRALL;
               cur_row_nxt = '0;
               cur_col_nxt = '0;
               clr_row_nxt = '0;
               clr_col_nxt = '0;
            end else if (bus.in_valid) begin
               if (bus.in_char >= CH_SPACE && bus.in_char <= CH_TILDE) begin
                  mem_wen_nxt  = 1'b1;
                  mem_addr_nxt = {cur_row_q, cur_col_q};
                  mem_data_nxt = bus.in_char;
                  if (cur_col_q == LAST_COL) begin
                     cur_row_nxt = row_inc;
                     cur_col_nxt = '0;
                     clr_col_nxt = '0;
                     state_nxt   = S_CLRLINE;
                  end else begin
                     cur_col_nxt = cur_col_q + COL_ONE;
                  end
               end else if (bus.in_char == CH_LF || bus.in_char == CH_CR) begin
                  cur_row_nxt = row_inc;
                  cur_col_nxt = '0;
                  clr_col_nxt = '0;
                  state_nxt   = S_CLRLINE;
               end else if (bus.in_char == CH_BS) begin
                  if (cur_col_q != '0) begin
                     cur_col_nxt  = cur_col_q - COL_ONE;
                     mem_wen_nxt  = 1'b1;
                     mem_addr_nxt = {cur_row_q, cur_col_q - COL_ONE};
                     mem_data_nxt = CH_SPACE;
                  end else if (cur_row_q != '0) begin
                     cur_row_nxt  = cur_row_q - ROW_ONE;
                     cur_col_nxt  = LAST_COL;
                     mem_wen_nxt  = 1'b1;
                     mem_addr_nxt = {cur_row_q - ROW_ONE, LAST_COL};
                     mem_data_nxt = CH_SPACE;
                  end
               end
            end
         end

         S_CLRLINE: begin
            mem_wen_nxt  = 1'b1;
            mem_addr_nxt = {cur_row_q, clr_col_q};
            mem_data_nxt = CH_SPACE;
            if (clr_col_q == LAST_COL) begin
               clr_col_nxt = '0;
               state_nxt   = S_IDLE;
            end else begin
               clr_col_nxt = clr_col_q + COL_ONE;
            end
         end

         S_CLRALL: begin
            mem_wen_nxt  = 1'b1;
            mem_addr_nxt = {clr_row_q, clr_col_q};
            mem_data_nxt = CH_SPACE;
            if (clr_col_q == LAST_COL) begin
               clr_col_nxt = '0;
               if (clr_row_q == LAST_ROW) begin
                  clr_row_nxt = '0;
                  state_nxt   = S_IDLE;
               end else begin
                  clr_row_nxt = clr_row_q + ROW_ONE;
               end
            end else begin
               clr_col_nxt = clr_col_q + COL_ONE;
            end
         end

         default: state_nxt = S_CLRALL;
      endcase
   end

endmodule

// File: tb/tb_scr_writer.sv
// tb/tb_scr_writer.sv - randomized and directed self-checking bench for scr_writer

module tb_scr_writer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   scr_writer_if bus ();

   scr_writer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: cursor as plain integers, pending clear work as a queue
   // of {addr, data} writes that the block must emit one per cycle.
   int          mrow = 0;
   int          mcol = 0;
   logic [19:0] pend[$];
   logic        exp_wen  = 1'b0;
   logic [11:0] exp_addr = '0;
   logic [7:0]  exp_data = '0;
   bit          in_rst   = 1'b0;
   bit          known    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic void push_line(input int r);
      for (int c = 0; c < 70; c++) pend.push_back({12'(r * 128 + c), 8'h20});
   endfunction

   function automatic void push_screen();
      for (int r = 0; r < 30; r++) push_line(r);
   endfunction

   function automatic void model_edge(input logic v, input logic [7:0] ch, input logic c, input logic r);
      logic [19:0] w;
      exp_wen = 1'b0;
      in_rst  = r;
      if (r) begin
         pend.delete();
         push_screen();
         mrow = 0; mcol = 0;
         exp_addr = '0; exp_data = '0;
         known = 1'b1;
      end else if (pend.size() > 0) begin
         w = pend.pop_front();
         exp_wen = 1'b1; exp_addr = w[19:8]; exp_data = w[7:0];
      end else if (c) begin
         push_screen();
         mrow = 0; mcol = 0;
      end else if (v) begin
         if (ch >= 8'h20 && ch <= 8'h7E) begin
            exp_wen = 1'b1; exp_addr = 12'(mrow * 128 + mcol); exp_data = ch;
            mcol++;
            if (mcol == 70) begin
               mcol = 0;
               mrow = (mrow + 1) % 30;
               push_line(mrow);
            end
         end else if (ch == 8'h0A || ch == 8'h0D) begin
            mcol = 0;
            mrow = (mrow + 1) % 30;
            push_line(mrow);
         end else if (ch == 8'h08) begin
            if (mcol > 0) begin
               mcol--;
               exp_wen = 1'b1; exp_addr = 12'(mrow * 128 + mcol); exp_data = 8'h20;
            end else if (mrow > 0) begin
               mrow--; mcol = 69;
               exp_wen = 1'b1; exp_addr = 12'(mrow * 128 + mcol); exp_data = 8'h20;
            end
         end
      end
   endfunction

   // One clock: inputs applied at the falling edge, outputs checked 1 ns after the rising edge.
   task automatic cycle(input logic v, input logic [7:0] ch, input logic c, input logic r);
      bus.in_valid = v;
      bus.in_char  = ch;
      bus.clr      = c;
      rst          = r;
      #1;
      if (!r && known) chk("in_ready", 32'(bus.in_ready), 32'((pend.size() == 0) && !c));
      @(posedge clk);
      model_edge(v, ch, c, r);
      #1;
      chk("mem_wen", 32'(bus.mem_wen), 32'(exp_wen));
      if (exp_wen || in_rst) begin
         chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
         chk("mem_data", 32'(bus.mem_data), 32'(exp_data));
      end
      chk("cur_row", 32'(bus.cur_row), 32'(mrow));
      chk("cur_col", 32'(bus.cur_col), 32'(mcol));
      chk("busy", 32'(bus.busy), 32'(pend.size() != 0));
      chk("mem_ren", 32'(bus.mem_ren), 32'd0);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] ch);
      cycle(1'b1, ch, 1'b0, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while (pend.size() > 0 && n < 3000) begin
         cycle(1'b0, 8'h00, 1'b0, 1'b0);
         n++;
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   function automatic logic [7:0] pick_char();
      int k = int'($urandom_range(0, 15));
      if (k <= 10) return 8'($urandom_range(32, 126));
      if (k == 11) return 8'h0A;
      if (k == 12) return 8'h0D;
      if (k <= 14) return 8'h08;
      return 8'($urandom_range(127, 255));
   endfunction

   initial begin
      bus.in_valid = 1'b0;
      bus.in_char  = 8'h00;
      bus.clr      = 1'b0;
      @(negedge clk);

      // Reset, then the full-screen clear that follows release.
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
      drain();

      // 'A' at (0,0), then a full line of printables back-to-back, wrapping into a line clear.
      send(8'h41);
      for (int i = 0; i < 69; i++) send(8'h42);
      drain();

      // Walk down to (29,5), then newline wraps to row 0 and clears it.
      for (int i = 0; i < 28; i++) begin
         send(8'h0A);
         drain();
      end
      for (int i = 0; i < 5; i++) send(8'h78);
      send(8'h0A);
      drain();

      // Backspace across a row boundary from (3,0).
      for (int i = 0; i < 3; i++) begin
         send(8'h0D);
         drain();
      end
      send(8'h08);
      send(8'h07);

      // clr together with in_valid: char dropped, full clear, then backspace at (0,0).
      cycle(1'b1, 8'h5A, 1'b1, 1'b0);
      drain();
      send(8'h08);
      send(8'h08);

      // Reset pulse in the middle of a full clear restarts it from address 0.
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 500; i++) cycle(1'b1, 8'h41, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      drain();

      // Random traffic with occasional clears and resets.
      for (int i = 0; i < 4000; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), pick_char(),
               1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1999) == 0));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
